// File: rtl/var_delay_line.sv
// Variable-length sample delay line: circular buffer with a per-accept delay tap.
// Latency: out_data/out_valid registered, 1 cycle after each accepted sample.
// Backpressure: none; accepts a sample on every cycle in_valid is high.
module var_delay_line #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] delay,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  primed,
   output logic [ADDR_WIDTH-1:0] fill_count
);

   localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(DEPTH - 1);

   // Sample storage; never cleared, zero-fill masks stale contents instead.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q,     wr_ptr_d;
   logic [ADDR_WIDTH-1:0] fill_q,       fill_d;
   logic                  out_valid_q,  out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,   out_data_d;

   logic [ADDR_WIDTH-1:0] d_eff;
   logic [ADDR_WIDTH-1:0] d_minus_1;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  accept;

   // Effective delay (0 behaves as 1), tap address and the primed flag.
   always_comb begin
      d_eff     = (delay == '0) ? ONE : delay;
      d_minus_1 = d_eff - ONE;
      // D-1 is never 0 mod DEPTH on this path, so the tap never aliases the write slot.
      rd_addr   = wr_ptr_q - d_minus_1;
      accept    = reset_n & ~flush & in_valid;
      primed    = (fill_q >= d_minus_1);
   end

   // Next-state for the stream registers; flush clears, an accept advances.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      fill_d      = fill_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      if (flush) begin
         wr_ptr_d   = '0;
         fill_d     = '0;
         out_data_d = '0;
      end else if (in_valid) begin
         wr_ptr_d    = wr_ptr_q + ONE;
         out_valid_d = 1'b1;
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + ONE;
         end
         if (d_eff == ONE) begin
            // Bypass the buffer so D=1 never depends on read-during-write.
            out_data_d = in_data;
         end else if (fill_q < d_minus_1) begin
            out_data_d = '0;
         end else begin
            out_data_d = mem_q[rd_addr];
         end
      end
   end

   // Stream state registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Buffer write on every accepted sample.
   always_ff @(posedge clock) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign fill_count = fill_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line (DEPTH=8, DATA_WIDTH=8).
// Reference keeps the full list of samples accepted since the last clear
// and answers out_data = x[k+1-D] (or 0 when that index is negative).
module tb_var_delay_line;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic [2:0] delay;
   logic       out_valid;
   logic [7:0] out_data;
   logic       primed;
   logic [2:0] fill_count;

   var_delay_line #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .delay     (delay),
      .out_valid (out_valid),
      .out_data  (out_data),
      .primed    (primed),
      .fill_count(fill_count)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [7:0] hist[$];
   logic       exp_ov;
   logic [7:0] exp_od;
   int         exp_fill;

   function automatic int effd(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
   task automatic cycle(input string tag, input bit v, input logic [7:0] d,
                        input logic [2:0] dl, input bit fl, input bit rn);
      int n;
      int idx;
      reset_n  = rn;
      flush    = fl;
      in_valid = v;
      in_data  = d;
      delay    = dl;
      if (!rn || fl) begin
         hist.delete();
         exp_fill = 0;
         exp_ov   = 1'b0;
         exp_od   = 8'h00;
      end else if (v) begin
         n = hist.size();
         hist.push_back(d);
         idx    = n + 1 - effd(int'(dl));
         exp_od = (idx >= 0) ? hist[idx] : 8'h00;
         exp_ov = 1'b1;
         exp_fill = (n + 1 > 7) ? 7 : n + 1;
      end else begin
         exp_ov = 1'b0;
      end
      @(posedge clock);
      #1;
      chk({tag, ".ov"},   32'(out_valid),  32'(exp_ov));
      chk({tag, ".od"},   32'(out_data),   32'(exp_od));
      chk({tag, ".fill"}, 32'(fill_count), 32'(exp_fill));
      chk({tag, ".prm"},  32'(primed),     32'(exp_fill >= effd(int'(dl)) - 1));
   endtask

   initial begin
      reset_n  = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      delay    = 3'd1;

      // Reset state
      cycle("rst", 1'b1, 8'h55, 3'd1, 1'b0, 1'b0);
      cycle("rst", 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
      chk("rst_ov",   32'(out_valid),  32'd0);
      chk("rst_od",   32'(out_data),   32'd0);
      chk("rst_fill", 32'(fill_count), 32'd0);
      chk("rst_prm_d1", 32'(primed),   32'd1);
      delay = 3'd3;
      #1;
      chk("rst_prm_d3", 32'(primed),   32'd0);

      // delay=3, accepts 1..5 back to back
      for (int i = 0; i < 5; i++) begin
         cycle("d3", 1'b1, 8'(i + 1), 3'd3, 1'b0, 1'b1);
         chk($sformatf("d3_const%0d", i), 32'(out_data), (i < 2) ? 32'd0 : 32'(i - 1));
      end
      cycle("d3_idle", 1'b0, 8'h00, 3'd3, 1'b0, 1'b1);
      chk("d3_ov_drop", 32'(out_valid), 32'd0);

      // delay=0 and delay=1 bypass
      cycle("fl", 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
      cycle("d0", 1'b1, 8'hA5, 3'd0, 1'b0, 1'b1);
      chk("d0_const", 32'(out_data), 32'hA5);
      chk("d0_prm",   32'(primed),   32'd1);
      cycle("fl", 1'b0, 8'h00, 3'd1, 1'b1, 1'b1);
      cycle("d1", 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1);
      chk("d1_const", 32'(out_data), 32'hA5);
      chk("d1_ov",    32'(out_valid), 32'd1);

      // delay=7, accepts 1..20: pointer wraps, fill saturates
      cycle("fl", 1'b0, 8'h00, 3'd7, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cycle("d7", 1'b1, 8'(i + 1), 3'd7, 1'b0, 1'b1);
         chk($sformatf("d7_const%0d", i), 32'(out_data), (i < 6) ? 32'd0 : 32'(i - 5));
      end
      chk("d7_sat", 32'(fill_count), 32'd7);

      // delay increase with enough history: no zero-fill
      cycle("fl", 1'b0, 8'h00, 3'd2, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cycle("d2", 1'b1, 8'(i + 1), 3'd2, 1'b0, 1'b1);
      cycle("d5", 1'b1, 8'd11, 3'd5, 1'b0, 1'b1);
      chk("d5_const", 32'(out_data), 32'd7);

      // flush beats in_valid; sample dropped
      cycle("fl", 1'b0, 8'h00, 3'd2, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cycle("pre_fl", 1'b1, 8'(i + 1), 3'd2, 1'b0, 1'b1);
      cycle("fl_v", 1'b1, 8'h77, 3'd2, 1'b1, 1'b1);
      chk("fl_v_ov", 32'(out_valid), 32'd0);
      cycle("post_fl", 1'b1, 8'd9, 3'd2, 1'b0, 1'b1);
      chk("post_fl_od",   32'(out_data),   32'd0);
      chk("post_fl_fill", 32'(fill_count), 32'd1);

      // reset mid-stream with in_valid high
      for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(i + 40), 3'd2, 1'b0, 1'b1);
      cycle("mid_rst", 1'b1, 8'h99, 3'd2, 1'b0, 1'b0);
      chk("mid_rst_ov",   32'(out_valid),  32'd0);
      chk("mid_rst_fill", 32'(fill_count), 32'd0);
      cycle("post_rst", 1'b1, 8'h31, 3'd2, 1'b0, 1'b1);
      chk("post_rst_od", 32'(out_data), 32'd0);
      cycle("post_rst", 1'b1, 8'h32, 3'd2, 1'b0, 1'b1);
      chk("post_rst_od2", 32'(out_data), 32'h31);

      // gapped in_valid at delay=4, output held during gaps
      cycle("fl", 1'b0, 8'h00, 3'd4, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cycle("gap", 1'b1, 8'(i + 1), 3'd4, 1'b0, 1'b1);
         chk($sformatf("gap_const%0d", i), 32'(out_data), (i < 3) ? 32'd0 : 32'(i - 2));
         for (int g = 0; g < 2; g++) begin
            cycle("gap_idle", 1'b0, 8'(g + 200), 3'd4, 1'b0, 1'b1);
            chk($sformatf("gap_hold%0d", i), 32'(out_data), (i < 3) ? 32'd0 : 32'(i - 2));
         end
      end

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         cycle("rnd", ($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)),
               (r == 0), (r != 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/var_delay_line.md
VAR_DELAY_LINE -- requirements
Module: var_delay_line

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, meaning sample width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 1024, meaning buffer entries, a power of two and at least 4.
REQ-003 The module SHALL have parameter ADDR_WIDTH, default 10, meaning pointer width, equal to log2(DEPTH).
REQ-004 The module SHALL have port clock, input, 1 bit, rising-edge clock.
REQ-005 The module SHALL have port reset_n, input, 1 bit, reset: synchronous, active-low.
REQ-006 The module SHALL have port flush, input, 1 bit, synchronous clear of stream state.
REQ-007 The module SHALL have port in_valid, input, 1 bit, sample accept strobe (no backpressure).
REQ-008 The module SHALL have port in_data, input, DATA_WIDTH bits, input sample.
REQ-009 The module SHALL have port delay, input, ADDR_WIDTH bits, requested delay in samples.
REQ-010 The module SHALL have port out_valid, output, 1 bit, one-cycle pulse per accepted sample.
REQ-011 The module SHALL have port out_data, output, DATA_WIDTH bits, delayed sample, registered.
REQ-012 The module SHALL have port primed, output, 1 bit, high when fill_count >= effective delay - 1.
REQ-013 The module SHALL have port fill_count, output, ADDR_WIDTH bits, accepted samples since clear, saturating.

Function
REQ-014 An "accept" SHALL be any rising edge with reset_n=1, flush=0 and in_valid=1.
REQ-015 Effective delay D SHALL be delay, with delay=0 treated as 1; legal range is therefore 1..DEPTH-1.
REQ-016 D SHALL be sampled on the accept cycle only, so a delay change takes effect on the next accept with no glitch or hold-over state.
REQ-017 On an accept, the sample SHALL be written to mem[wr_ptr], and wr_ptr SHALL then increment modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-018 For the k-th accept (k counted from 0 since the last clear), out_data on the following cycle SHALL equal x[k+1-D], where x[i] is the i-th accepted sample.
REQ-019 If D=1, out_data SHALL equal in_data of the same accept, via a write bypass with no memory read-during-write dependency.
REQ-020 If D>=2, the read address SHALL be (wr_ptr - (D-1)) mod DEPTH, evaluated before the increment.
REQ-021 If fill_count (pre-accept) < D-1, out_data SHALL be 0 (zero-fill), so stale memory contents are never emitted.
REQ-022 out_valid SHALL be 1 exactly in the cycle after each accept and 0 otherwise; latency is 1 cycle.
REQ-023 out_data SHALL hold its value between accepts.
REQ-024 fill_count SHALL increment on each accept and saturate at DEPTH-1.
REQ-025 primed SHALL be combinational from fill_count and the current delay input.
REQ-026 A delay change to a larger D SHALL re-apply zero-fill only if fill_count < D-1; otherwise historic samples SHALL be output.
REQ-027 When flush=1, wr_ptr, fill_count, out_valid and out_data SHALL be cleared to 0, and memory SHALL NOT be cleared.
REQ-028 When flush and in_valid are both 1, flush SHALL win and the sample SHALL be dropped.
REQ-029 The accept rate SHALL support in_valid asserted every cycle (full throughput).
REQ-030 Behaviour SHALL be cycle-equivalent to a DEPTH-long shift register tapped at position D-1 whose shift input is driven by in_valid.

Reset
REQ-031 When reset_n=0, the block SHALL apply identical action to flush and SHALL take priority over flush and in_valid.
REQ-032 After reset the output values SHALL be: out_valid=0, out_data=0, fill_count=0, and primed=1 iff D=1.
REQ-033 Reset asserted mid-stream SHALL discard history, so subsequent outputs zero-fill as after power-up.

Verification (DEPTH=8, DATA_WIDTH=8)
REQ-034 Bench SHALL cover: delay=3, accepts 1,2,3,4,5 back-to-back -> out_data 0,0,1,2,3, with out_valid high 5 cycles, lagging 1 cycle.
REQ-035 Bench SHALL cover: delay=0 and delay=1, accept 0xA5 -> next cycle out_data=0xA5, out_valid=1, primed=1.
REQ-036 Bench SHALL cover: delay=7, accepts 1..20 -> wr_ptr wraps twice, outputs 0 x6 then 1..14, and fill_count saturates at 7.
REQ-037 Bench SHALL cover: after 10 accepts at delay=2, switch to delay=5 and accept 11 -> out_data=7, with no zero-fill.
REQ-038 Bench SHALL cover: flush with in_valid=1 after 6 accepts, then accept 9 at delay=2 -> flushed sample dropped, out_data=0, fill_count=1.
REQ-039 Bench SHALL cover: reset_n=0 for one cycle mid-stream with in_valid=1 -> out_valid=0, fill_count=0, and next outputs zero-filled.
REQ-040 Bench SHALL cover: gapped in_valid (1 of 3 cycles) at delay=4 -> outputs equal the gapless case, and out_data is held during gaps.
